// File: rtl/shift_arbiter_pkg.sv
// Constants and state encoding shared by the shift arbiter and its shifter.
package shift_arbiter_pkg;

  localparam int SHIFT_W = 8;
  localparam int AMT_W   = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational 8-bit logical-right barrel shifter.
// Built as log2 stages, each shifting by a power of two.
module barrel_shifter_8bit
  import shift_arbiter_pkg::*;
(
  input  logic [SHIFT_W-1:0] in,
  input  logic [AMT_W-1:0]   ctrl,
  output logic [SHIFT_W-1:0] out
);

  logic [SHIFT_W-1:0] stage [AMT_W+1];

  assign stage[0] = in;

  generate
    for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
      assign stage[gi+1] = ctrl[gi] ? (stage[gi] >> (1 << gi)) : stage[gi];
    end
  endgenerate

  assign out = stage[AMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NREQ requesters,
// with a one-entry result register tagged by the winning requester ID.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*SHIFT_W-1:0]  req_data,
  input  logic [NREQ*AMT_W-1:0]    req_amt,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [SHIFT_W-1:0]       rsp_data,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy
);

  rsp_state_t         state_q, state_d;
  logic [SHIFT_W-1:0] data_q, data_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;

  logic [SHIFT_W-1:0] data_arr [NREQ];
  logic [AMT_W-1:0]   amt_arr  [NREQ];

  logic [IDW:0]       cand;
  logic [IDW-1:0]     win;
  logic               found;
  logic               load_en;
  logic               accept;
  logic [SHIFT_W-1:0] shifted;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*SHIFT_W +: SHIFT_W];
      assign amt_arr[gi]  = req_amt[gi*AMT_W +: AMT_W];
    end
  endgenerate

  // Scan from rr_ptr upward; explicit subtract keeps the wrap exact for any NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  assign load_en = (state_q == EMPTY) || rsp_ready;
  // rst_n gating keeps every ready low while reset is held.
  assign accept  = found && load_en && rst_n;
  assign req_ready = accept ? (NREQ'(1) << win) : '0;

  barrel_shifter_8bit u_shifter (
    .in   (data_arr[win]),
    .ctrl (amt_arr[win]),
    .out  (shifted)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      data_d   = shifted;
      id_d     = win;
      rr_ptr_d = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = rsp_valid || (|req_valid);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with NREQ=4.
module tb_shift_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [11:0] req_amt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] a);
    req_data[i*8 +: 8] = d;
    req_amt[i*3 +: 3]  = a;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [7:0] d, input logic [1:0] id);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    chk({tag, "_data"},  32'(rsp_data),  32'(d));
    chk({tag, "_id"},    32'(rsp_id),    32'(id));
  endtask

  initial begin
    logic [7:0] exp_d;
    logic [3:0] exp_rdy;

    rst_n     = 1'b1;
    req_valid = 4'b0001;
    req_data  = '0;
    req_amt   = '0;
    rsp_ready = 1'b0;

    // Reset asserted mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk_rsp("reset", 1'b0, 8'h00, 2'd0);
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_busy_req", 32'(busy), 32'h1);
    #9;
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    tick();
    chk_rsp("idle", 1'b0, 8'h00, 2'd0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_ready", 32'(req_ready), 32'h0);

    // Single request: B6 >> 3 = 16
    rsp_ready = 1'b1;
    set_req(2, 8'hB6, 3'd3);
    req_valid = 4'b0100;
    #1 chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    chk_rsp("single", 1'b1, 8'h16, 2'd2);
    req_valid = 4'b0000;
    tick();
    chk_rsp("drain", 1'b0, 8'h16, 2'd2);
    chk("drain_busy", 32'(busy), 32'h0);

    // Requester 3 alone: 7F >> 7 = 00; pointer wraps to 0
    set_req(3, 8'h7F, 3'd7);
    req_valid = 4'b1000;
    #1 chk("r3_ready", 32'(req_ready), 32'h8);
    tick();
    chk_rsp("amt7_7f", 1'b1, 8'h00, 2'd3);

    // Round robin with all four valid
    for (int i = 0; i < 4; i++) set_req(i, 8'hFF, 3'(i));
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      exp_rdy = 4'b0001 << (c % 4);
      exp_d   = 8'hFF;
      exp_d   = exp_d >> (c % 4);
      #1 chk($sformatf("rr_ready%0d", c), 32'(req_ready), 32'(exp_rdy));
      tick();
      chk_rsp($sformatf("rr%0d", c), 1'b1, exp_d, 2'(c % 4));
    end

    // Backpressure with requesters 1 and 3 valid
    rsp_ready = 1'b0;
    set_req(1, 8'hA5, 3'd0);
    set_req(3, 8'h80, 3'd7);
    req_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_ready%0d", c), 32'(req_ready), 32'h0);
      chk_rsp($sformatf("bp%0d", c), 1'b1, 8'h1F, 2'd3);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("rel_ready1", 32'(req_ready), 32'h2);
    tick();
    chk_rsp("amt0_a5", 1'b1, 8'hA5, 2'd1);
    req_valid = 4'b1000;
    #1 chk("rel_ready3", 32'(req_ready), 32'h8);
    tick();
    chk_rsp("amt7_80", 1'b1, 8'h01, 2'd3);
    req_valid = 4'b0000;
    tick();
    chk_rsp("rel_drain", 1'b0, 8'h01, 2'd3);
    chk("rel_busy", 32'(busy), 32'h0);

    // Reset mid-stream: pointer must return to 0
    rsp_ready = 1'b0;
    set_req(2, 8'hF0, 3'd4);
    req_valid = 4'b1110;
    #1 chk("mr_ready1", 32'(req_ready), 32'h2);
    tick();
    chk_rsp("mr_full", 1'b1, 8'hA5, 2'd1);
    #1 chk("mr_stall", 32'(req_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_rsp("mr_reset", 1'b0, 8'h00, 2'd0);
    chk("mr_reset_ready", 32'(req_ready), 32'h0);
    chk("mr_reset_busy", 32'(busy), 32'h1);
    tick();
    chk_rsp("mr_held", 1'b0, 8'h00, 2'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1 chk("mr_first_ready", 32'(req_ready), 32'h2);
    tick();
    chk_rsp("mr_first", 1'b1, 8'hA5, 2'd1);
    req_valid = 4'b1100;
    #1 chk("mr_second_ready", 32'(req_ready), 32'h4);
    tick();
    chk_rsp("mr_second", 1'b1, 8'h0F, 2'd2);
    req_valid = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
